fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE picks the next owner, OWN streams that owner's words.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Width of a producer index; a single producer still needs one bit.
  function automatic int id_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  // Width of a burst counter able to hold 0..max_burst.
  function automatic int cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotated priority encoder: finds the first asserted request at or after
// rr_ptr, wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ and keep the first hit.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // The modulo keeps every candidate inside 0..NUM_REQ-1, so indices
      // beyond the last producer never appear for non-power-of-2 counts.
      cand     = (int'(rr_ptr) + off) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single write port of an async FIFO between NUM_REQ producers.
// Round-robin ownership, at most MAX_BURST words per grant, and the FIFO
// full flag gates every write so no word is presented while full.
//
// Handshake: a producer raises req[i] with stable req_data slice i and holds
// both until ack[i]. ack[i] is a combinational accept in the same cycle the
// word is driven onto fifo_wdata with fifo_winc high; the word is taken on
// that clock edge and the producer may drop req or present its next word
// right after it.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_winc,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int CNT_W = cnt_width(MAX_BURST);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             owner_req;
  logic             xfer;
  logic [ID_W-1:0]  owner_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Owner-side handshake terms; a transfer only ever happens while owning.
  always_comb begin
    owner_req  = req[owner_q];
    xfer       = (state_q == OWN) && owner_req && !fifo_full;
    owner_next = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);
  end

  // Next-state logic and write-port outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    ack         = '0;
    fifo_winc   = 1'b0;
    fifo_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        // Arbitration cycle: no write here, so a fresh grant costs one cycle.
        if (pick_found) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = OWN;
        end
      end

      OWN: begin
        if (xfer) begin
          fifo_winc      = 1'b1;
          ack[owner_q]   = 1'b1;
          fifo_wdata     = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        end

        // Give up the port when the owner goes quiet or its last beat is
        // accepted; a full stall alone never releases (no timeout).
        if (!owner_req || (xfer && burst_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          rr_ptr_d = owner_next;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Status outputs straight from registers so reset clears them at once.
  always_comb begin
    grant_id = owner_q;
    busy     = (state_q == OWN);
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a default 4-producer / burst-4
// instance and a 3-producer / burst-1 instance sharing clock and reset.
module tb_fifo_wr_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: NUM_REQ=4, MAX_BURST=4 ----------------
  logic [3:0]  req_a;
  logic [31:0] req_data_a;
  logic        full_a;
  logic [3:0]  ack_a;
  logic        winc_a;
  logic [7:0]  wdata_a;
  logic [1:0]  grant_id_a;
  logic        busy_a;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_a),
    .req_data   (req_data_a),
    .fifo_full  (full_a),
    .ack        (ack_a),
    .fifo_winc  (winc_a),
    .fifo_wdata (wdata_a),
    .grant_id   (grant_id_a),
    .busy       (busy_a)
  );

  // ---------------- DUT B: NUM_REQ=3, MAX_BURST=1 ----------------
  logic [2:0]  req_b;
  logic [23:0] req_data_b;
  logic        full_b;
  logic [2:0]  ack_b;
  logic        winc_b;
  logic [7:0]  wdata_b;
  logic [1:0]  grant_id_b;
  logic        busy_b;

  fifo_wr_arbiter #(
    .NUM_REQ    (3),
    .DATA_WIDTH (8),
    .MAX_BURST  (1)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_b),
    .req_data   (req_data_b),
    .fifo_full  (full_b),
    .ack        (ack_b),
    .fifo_winc  (winc_b),
    .fifo_wdata (wdata_b),
    .grant_id   (grant_id_b),
    .busy       (busy_b)
  );

  // ---------------- scoreboard ----------------
  // Entries are {producer id, word}, pushed when a write is expected and
  // popped when the DUT raises fifo_winc.
  logic [9:0] exp_q[$];
  logic [9:0] exp_b_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Monitor for DUT A: scoreboard pop plus ack/data consistency each cycle.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [3:0] want_ack;
    if (rst_n) begin
      want_ack = winc_a ? (4'b0001 << grant_id_a) : 4'b0000;
      n_total++;
      if (ack_a !== want_ack || (!winc_a && wdata_a !== 8'h00))
        $display("FAIL a_ack_shape: ack=%b wdata=%h winc=%b, required ack=%b (wdata 0 when idle)",
                 ack_a, wdata_a, winc_a, want_ack);
      else n_pass++;
      if (winc_a) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL a_sb_unexpected: got id=%0d data=%h, required no write", grant_id_a, wdata_a);
        end else begin
          e = exp_q.pop_front();
          if ({grant_id_a, wdata_a} !== e)
            $display("FAIL a_sb_word: got id=%0d data=%h, required id=%0d data=%h",
                     grant_id_a, wdata_a, e[9:8], e[7:0]);
          else n_pass++;
        end
      end
    end
  end

  // Monitor for DUT B.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [2:0] want_ack;
    if (rst_n) begin
      want_ack = winc_b ? (3'b001 << grant_id_b) : 3'b000;
      n_total++;
      if (ack_b !== want_ack || (!winc_b && wdata_b !== 8'h00))
        $display("FAIL b_ack_shape: ack=%b wdata=%h winc=%b, required ack=%b (wdata 0 when idle)",
                 ack_b, wdata_b, winc_b, want_ack);
      else n_pass++;
      if (winc_b) begin
        n_total++;
        if (exp_b_q.size() == 0) begin
          $display("FAIL b_sb_unexpected: got id=%0d data=%h, required no write", grant_id_b, wdata_b);
        end else begin
          e = exp_b_q.pop_front();
          if ({grant_id_b, wdata_b} !== e)
            $display("FAIL b_sb_word: got id=%0d data=%h, required id=%0d data=%h",
                     grant_id_b, wdata_b, e[9:8], e[7:0]);
          else n_pass++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Synchronous-looking reset entry/exit; returns at posedge+1 with rst_n high.
  task automatic do_reset();
    rst_n = 1'b0;
    req_a = '0; full_a = 1'b0; req_data_a = '0;
    req_b = '0; full_b = 1'b0; req_data_b = '0;
    exp_q.delete();
    exp_b_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = '0; full_a = 1'b0; req_data_a = '0;
    req_b = '0; full_b = 1'b0; req_data_b = '0;
    @(posedge clk); #1;
    n_total++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy_a); else n_pass++;
    n_total++; if (winc_a !== 1'b0) $display("FAIL rst_winc: got %b, required 0", winc_a); else n_pass++;
    n_total++; if (ack_a !== 4'b0) $display("FAIL rst_ack: got %b, required 0000", ack_a); else n_pass++;
    n_total++; if (grant_id_a !== 2'd0) $display("FAIL rst_grant: got %0d, required 0", grant_id_a); else n_pass++;
    n_total++; if (wdata_a !== 8'h00) $display("FAIL rst_wdata: got %h, required 00", wdata_a); else n_pass++;
    n_total++; if (busy_b !== 1'b0) $display("FAIL rst_busy_b: got %b, required 0", busy_b); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (busy_a !== 1'b0) $display("FAIL rst_idle_noreq: busy=%b, required 0", busy_a); else n_pass++;
    @(posedge clk); #1;
  endtask

  // Single producer 2: one idle cycle, four words, one gap, then re-grant.
  task automatic test_single();
    bit exp_w[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    req_data_a = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_a = 4'b0100;
    for (int k = 0; k < 5; k++) exp_q.push_back({2'd2, 8'hA5});
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_total++;
      if (winc_a !== exp_w[c]) $display("FAIL single_winc c%0d: got %b, required %b", c, winc_a, exp_w[c]);
      else n_pass++;
      n_total++;
      if (busy_a !== exp_w[c]) $display("FAIL single_busy c%0d: got %b, required %b", c, busy_a, exp_w[c]);
      else n_pass++;
      if (exp_w[c]) begin
        n_total++;
        if (grant_id_a !== 2'd2) $display("FAIL single_grant c%0d: got %0d, required 2", c, grant_id_a);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    req_a = '0;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL single_drain: %0d words left, required 0", exp_q.size());
    else n_pass++;
  endtask

  // All four request: bursts of four in order 0,1,2,3,0 with a gap cycle.
  task automatic test_round_robin();
    do_reset();
    req_data_a = {8'h13, 8'h12, 8'h11, 8'h10};
    req_a = 4'b1111;
    for (int k = 0; k < 17; k++) exp_q.push_back({2'((k / 4) % 4), 8'(16 + (k / 4) % 4)});
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      n_total++;
      if (busy_a !== (c % 5 != 0)) $display("FAIL rr_busy c%0d: got %b, required %b", c, busy_a, (c % 5 != 0));
      else n_pass++;
      if (c % 5 != 0) begin
        n_total++;
        if (grant_id_a !== 2'((c / 5) % 4))
          $display("FAIL rr_grant c%0d: got %0d, required %0d", c, grant_id_a, (c / 5) % 4);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    req_a = '0;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL rr_drain: %0d words left, required 0", exp_q.size());
    else n_pass++;
  endtask

  // Owner 1 stalls on full at burst_cnt=2, then finishes two words and releases.
  task automatic test_full_stall();
    do_reset();
    req_data_a = {8'h00, 8'h00, 8'h21, 8'h00};
    req_a = 4'b0010;
    for (int k = 0; k < 4; k++) exp_q.push_back({2'd1, 8'h21});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (winc_a !== (c != 0)) $display("FAIL stall_pre c%0d: winc=%b, required %b", c, winc_a, (c != 0));
      else n_pass++;
      @(posedge clk); #1;
    end
    full_a = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if (winc_a !== 1'b0 || ack_a !== 4'b0)
        $display("FAIL stall_quiet c%0d: winc=%b ack=%b, required 0/0000", c, winc_a, ack_a);
      else n_pass++;
      n_total++;
      if (grant_id_a !== 2'd1 || busy_a !== 1'b1)
        $display("FAIL stall_hold c%0d: grant=%0d busy=%b, required 1/1", c, grant_id_a, busy_a);
      else n_pass++;
      @(posedge clk); #1;
    end
    full_a = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if (winc_a !== 1'b1) $display("FAIL stall_resume c%0d: winc=%b, required 1", c, winc_a);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++;
    if (busy_a !== 1'b0 || winc_a !== 1'b0)
      $display("FAIL stall_release: busy=%b winc=%b, required 0/0", busy_a, winc_a);
    else n_pass++;
    @(posedge clk); #1;
    req_a = '0;
    @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL stall_drain: %0d words left, required 0", exp_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  // Owner 3 drops req after one word; pointer wraps to 0 and producer 0 wins.
  task automatic test_drop_wrap();
    do_reset();
    req_data_a = {8'h13, 8'h12, 8'h11, 8'h10};
    req_a = 4'b1000;
    exp_q.push_back({2'd3, 8'h13});
    exp_q.push_back({2'd0, 8'h10});
    @(negedge clk);
    n_total++; if (busy_a !== 1'b0) $display("FAIL drop_idle: busy=%b, required 0", busy_a); else n_pass++;
    @(posedge clk); #1;
    req_a = 4'b1001;
    @(negedge clk);
    n_total++;
    if (winc_a !== 1'b1 || grant_id_a !== 2'd3)
      $display("FAIL drop_word3: winc=%b grant=%0d, required 1/3", winc_a, grant_id_a);
    else n_pass++;
    @(posedge clk); #1;
    req_a = 4'b0101;
    @(negedge clk);
    n_total++;
    if (busy_a !== 1'b1 || winc_a !== 1'b0 || grant_id_a !== 2'd3)
      $display("FAIL drop_noxfer: busy=%b winc=%b grant=%0d, required 1/0/3", busy_a, winc_a, grant_id_a);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (busy_a !== 1'b0) $display("FAIL drop_release: busy=%b, required 0", busy_a); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (grant_id_a !== 2'd0 || winc_a !== 1'b1)
      $display("FAIL drop_wrap_grant: grant=%0d winc=%b, required 0/1", grant_id_a, winc_a);
    else n_pass++;
    @(posedge clk); #1;
    req_a = '0;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drop_drain: %0d words left, required 0", exp_q.size());
    else n_pass++;
  endtask

  // Reset pulsed between edges mid-burst clears outputs at once.
  task automatic test_async_reset();
    do_reset();
    req_data_a = {8'h13, 8'h12, 8'h11, 8'h10};
    req_a = 4'b1111;
    exp_q.push_back({2'd0, 8'h10});
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #2;
    n_total++;
    if (winc_a !== 1'b1) $display("FAIL arst_pre: winc=%b, required 1", winc_a); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ack_a !== 4'b0 || winc_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL arst_clear: ack=%b winc=%b busy=%b, required 0000/0/0", ack_a, winc_a, busy_a);
    else n_pass++;
    n_total++;
    if (grant_id_a !== 2'd0 || wdata_a !== 8'h00)
      $display("FAIL arst_regs: grant=%0d wdata=%h, required 0/00", grant_id_a, wdata_a);
    else n_pass++;
    req_a = 4'b0110;
    #1;
    rst_n = 1'b1;
    exp_q.push_back({2'd1, 8'h11});
    @(negedge clk);
    n_total++; if (busy_a !== 1'b0) $display("FAIL arst_idle: busy=%b, required 0", busy_a); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (grant_id_a !== 2'd1 || winc_a !== 1'b1)
      $display("FAIL arst_first_grant: grant=%0d winc=%b, required 1/1", grant_id_a, winc_a);
    else n_pass++;
    @(posedge clk); #1;
    req_a = '0;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL arst_drain: %0d words left, required 0", exp_q.size());
    else n_pass++;
  endtask

  // NUM_REQ=3, MAX_BURST=1: one word per two cycles, ids 0,1,2,0,...
  task automatic test_nr3_mb1();
    do_reset();
    req_data_b = {8'h22, 8'h21, 8'h20};
    req_b = 3'b111;
    for (int k = 0; k < 6; k++) exp_b_q.push_back({2'(k % 3), 8'(32 + k % 3)});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_total++;
      if (busy_b !== (c % 2 == 1)) $display("FAIL nr3_busy c%0d: got %b, required %b", c, busy_b, (c % 2 == 1));
      else n_pass++;
      n_total++;
      if (grant_id_b === 2'd3) $display("FAIL nr3_range c%0d: grant=%0d, required <3", c, grant_id_b);
      else n_pass++;
      if (c % 2 == 1) begin
        n_total++;
        if (grant_id_b !== 2'(((c - 1) / 2) % 3))
          $display("FAIL nr3_grant c%0d: got %0d, required %0d", c, grant_id_b, ((c - 1) / 2) % 3);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    req_b = '0;
    n_total++;
    if (exp_b_q.size() != 0) $display("FAIL nr3_drain: %0d words left, required 0", exp_b_q.size());
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop_wrap();
    test_async_reset();
    test_nr3_mb1();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
